mod_sequencer: RTL and testbench
================================

MOD_SEQUENCER -- requirements
Module: mod_sequencer

Interface
REQ-001 SHALL have parameter SYM_CYCLES, default 1000, meaning clocks per transmitted symbol (legal range 2..65535).
REQ-002 SHALL have parameter F0_WORD, default 16'd655, meaning the DDS frequency word for carrier / FSK space.
REQ-003 SHALL have parameter F1_WORD, default 16'd1310, meaning the DDS frequency word for FSK mark.
REQ-004 clk  in  1  single system clock; all state changes on the rising edge.
REQ-005 rst_n  in  1  reset, asynchronous and active-low.
REQ-006 init  in  1  level; when sampled high, requests a datapath phase-accumulator clear and aborts any transfer.
REQ-007 start  in  1  level; a rising edge requests transmission of one message.
REQ-008 SW  in  10  message bits, captured only at load.
REQ-009 mode  in  1  scheme select, high bit.
REQ-010 sel  in  1  scheme select, low bit.
REQ-011 freq_word  out  16  frequency word to the DDS datapath.
REQ-012 amp_en  out  1  carrier amplitude enable.
REQ-013 phase_inv  out  1  180-degree phase inversion request.
REQ-014 acc_clr  out  1  one-cycle phase-accumulator clear pulse.
REQ-015 sym_strobe  out  1  one-cycle pulse on the first clock of each symbol.
REQ-016 bit_idx  out  4  index of the symbol currently sent (0..9).
REQ-017 busy  out  1  high from LOAD through the last SEND cycle.
REQ-018 done  out  1  one-cycle pulse after the tenth symbol.

Function
REQ-019 FSM states SHALL be IDLE, INIT, LOAD, SEND and DONE; all outputs SHALL be registered.
REQ-020 start SHALL be edge-detected with a registered copy; the edge is start=1 while the previous sample was 0, so a held start triggers once.
REQ-021 IDLE->INIT SHALL occur on init=1; init has priority over a simultaneous start edge.
REQ-022 INIT SHALL last exactly one cycle with acc_clr=1 and then go to IDLE; init held high re-enters INIT every other cycle.
REQ-023 IDLE->LOAD SHALL occur on a start edge; LOAD captures SW into a 10-bit shift register, captures scheme={mode,sel}, and clears bit_idx and the symbol counter.
REQ-024 LOAD->SEND SHALL occur after one cycle; the start-edge sample at cycle k gives the first sym_strobe at cycle k+2.
REQ-025 Bits SHALL be sent MSB first (SW[9] first); each symbol lasts exactly SYM_CYCLES clocks.
REQ-026 In SEND, the symbol counter SHALL count 0..SYM_CYCLES-1, and sym_strobe SHALL be high when the counter is 0.
REQ-027 On counter wrap, the shift register SHALL shift left, bit_idx SHALL increment, and after the symbol with bit_idx=9, SEND SHALL go to DONE.
REQ-028 Scheme 00 (ASK) SHALL drive amp_en=bit, freq_word=F0_WORD and phase_inv=0.
REQ-029 Scheme 01 (FSK) SHALL drive freq_word=bit?F1_WORD:F0_WORD, amp_en=1 and phase_inv=0.
REQ-030 Scheme 10 (PSK) SHALL drive phase_inv=bit, amp_en=1 and freq_word=F0_WORD.
REQ-031 Scheme 11 SHALL behave as scheme 00.
REQ-032 Output values for a symbol SHALL change in the same cycle as that symbol's sym_strobe and hold for the whole symbol.
REQ-033 DONE SHALL last one cycle with done=1 and then return to IDLE; a start edge in DONE is ignored.
REQ-034 In IDLE, INIT, LOAD and DONE, outputs SHALL be amp_en=0, phase_inv=0 and freq_word=F0_WORD.
REQ-035 Changes to SW, mode or sel during LOAD+1..DONE SHALL have no effect on the message in progress.
REQ-036 A start edge during LOAD or SEND SHALL be ignored and SHALL NOT be queued.
REQ-037 init=1 during LOAD or SEND SHALL abort to INIT next cycle; done SHALL NOT pulse and busy SHALL drop with INIT.

Reset
REQ-038 rst_n=0 SHALL immediately force state IDLE and set freq_word=F0_WORD, amp_en=0, phase_inv=0, acc_clr=0, sym_strobe=0, bit_idx=0, busy=0 and done=0.
REQ-039 On reset, the start edge register SHALL clear to 0, so start held high through reset release produces one transmission.
REQ-040 Reset asserted mid-SEND SHALL discard the message; no done pulse SHALL be issued.

Verification (SYM_CYCLES=4, F0_WORD=100, F1_WORD=200)
REQ-041 Bench SHALL check: init high 1 cycle from IDLE -> acc_clr high exactly 1 cycle, busy stays 0.
REQ-042 Bench SHALL check: SW=10'b1000110101, {mode,sel}=01, start rises and is held -> 10 sym_strobes 4 cycles apart, freq_word sequence 200,100,100,100,200,200,100,200,100,200, then one done pulse and no second transmission.
REQ-043 Bench SHALL check: same SW, {mode,sel}=00, with SW changed to 10'b1001101101 one cycle after LOAD -> amp_en follows 1,0,0,0,1,1,0,1,0,1 (the original SW).
REQ-044 Bench SHALL check: {mode,sel}=10, SW=10'h3FF -> phase_inv=1 for 40 cycles, amp_en=1, done at cycle 42 after the start edge.
REQ-045 Bench SHALL check: init=1 at bit_idx=5 -> INIT next cycle with acc_clr=1, busy=0, no done pulse, and a later start edge sends the full message again.
REQ-046 Bench SHALL check: rst_n low mid-SEND -> all outputs at reset values asynchronously, with start held high across release -> exactly one new transmission.

Source files
------------

// File: rtl/mod_sequencer_if.sv
// Control/status bundle between a host and the symbol sequencer.
// master drives the message request side; slave drives the DDS control side.
interface mod_sequencer_if;
    logic        init;
    logic        start;
    logic [9:0]  SW;
    logic        mode;
    logic        sel;
    logic [15:0] freq_word;
    logic        amp_en;
    logic        phase_inv;
    logic        acc_clr;
    logic        sym_strobe;
    logic [3:0]  bit_idx;
    logic        busy;
    logic        done;

    modport master (
        output init, start, SW, mode, sel,
        input  freq_word, amp_en, phase_inv, acc_clr, sym_strobe, bit_idx, busy, done
    );

    modport slave (
        input  init, start, SW, mode, sel,
        output freq_word, amp_en, phase_inv, acc_clr, sym_strobe, bit_idx, busy, done
    );
endinterface

// File: rtl/mod_sequencer.sv
// Sends a 10-bit message MSB first as ASK/FSK/PSK symbols to a DDS; all outputs registered.
// First sym_strobe two cycles after the start edge; no backpressure, start edges while busy are dropped.
module mod_sequencer #(
    parameter int unsigned SYM_CYCLES = 1000,
    parameter logic [15:0] F0_WORD    = 16'd655,
    parameter logic [15:0] F1_WORD    = 16'd1310
) (
    input logic            clk,
    input logic            rst_n,
    mod_sequencer_if.slave bus
);
    typedef enum logic [2:0] {S_IDLE, S_INIT, S_LOAD, S_SEND, S_DONE} state_t;

    localparam logic [15:0] LP_LAST = 16'(SYM_CYCLES - 1);

    state_t      r_state, w_next;
    logic        r_start_d;
    logic        w_start_edge;
    logic        w_sym_wrap;
    logic [9:0]  r_shift, w_shift_nxt;
    logic [1:0]  r_scheme, w_scheme_nxt;
    logic [15:0] r_cnt, w_cnt_nxt;
    logic [3:0]  r_bit_idx, w_bit_nxt;

    logic [15:0] r_freq_word, w_freq_nxt;
    logic        r_amp_en, w_amp_nxt;
    logic        r_phase_inv, w_ph_nxt;
    logic        r_acc_clr, w_clr_nxt;
    logic        r_sym_strobe, w_strobe_nxt;
    logic        r_busy, w_busy_nxt;
    logic        r_done, w_done_nxt;

    assign w_start_edge = bus.start & ~r_start_d;
    assign w_sym_wrap   = (r_cnt == LP_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_start_d <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_start_d <= bus.start;
        end
    end

    // init wins over a start edge and aborts a message in flight
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (bus.init)          w_next = S_INIT;
                else if (w_start_edge) w_next = S_LOAD;
            end
            S_INIT: w_next = S_IDLE;
            S_LOAD: w_next = bus.init ? S_INIT : S_SEND;
            S_SEND: begin
                if (bus.init)                            w_next = S_INIT;
                else if (w_sym_wrap && r_bit_idx == 4'd9) w_next = S_DONE;
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_shift_nxt  = r_shift;
        w_scheme_nxt = r_scheme;
        w_cnt_nxt    = r_cnt;
        w_bit_nxt    = r_bit_idx;
        if (w_next == S_LOAD) begin
            w_shift_nxt  = bus.SW;
            w_scheme_nxt = {bus.mode, bus.sel};
            w_cnt_nxt    = 16'd0;
            w_bit_nxt    = 4'd0;
        end else if (r_state == S_SEND && w_next == S_SEND) begin
            if (w_sym_wrap) begin
                w_cnt_nxt   = 16'd0;
                w_shift_nxt = {r_shift[8:0], 1'b0};
                w_bit_nxt   = r_bit_idx + 4'd1;
            end else begin
                w_cnt_nxt   = r_cnt + 16'd1;
            end
        end else if (w_next == S_INIT) begin
            w_cnt_nxt = 16'd0;
            w_bit_nxt = 4'd0;
        end
    end

    // Outputs are computed from the next state so they register in step with it
    always_comb begin
        w_freq_nxt   = F0_WORD;
        w_amp_nxt    = 1'b0;
        w_ph_nxt     = 1'b0;
        w_strobe_nxt = (w_next == S_SEND) && (w_cnt_nxt == 16'd0);
        w_busy_nxt   = (w_next == S_LOAD) || (w_next == S_SEND);
        w_done_nxt   = (w_next == S_DONE);
        w_clr_nxt    = (w_next == S_INIT);
        if (w_next == S_SEND) begin
            case (w_scheme_nxt)
                2'b01: begin
                    w_freq_nxt = w_shift_nxt[9] ? F1_WORD : F0_WORD;
                    w_amp_nxt  = 1'b1;
                end
                2'b10: begin
                    w_ph_nxt  = w_shift_nxt[9];
                    w_amp_nxt = 1'b1;
                end
                default: w_amp_nxt = w_shift_nxt[9];
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shift      <= 10'd0;
            r_scheme     <= 2'd0;
            r_cnt        <= 16'd0;
            r_bit_idx    <= 4'd0;
            r_freq_word  <= F0_WORD;
            r_amp_en     <= 1'b0;
            r_phase_inv  <= 1'b0;
            r_acc_clr    <= 1'b0;
            r_sym_strobe <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_shift      <= w_shift_nxt;
            r_scheme     <= w_scheme_nxt;
            r_cnt        <= w_cnt_nxt;
            r_bit_idx    <= w_bit_nxt;
            r_freq_word  <= w_freq_nxt;
            r_amp_en     <= w_amp_nxt;
            r_phase_inv  <= w_ph_nxt;
            r_acc_clr    <= w_clr_nxt;
            r_sym_strobe <= w_strobe_nxt;
            r_busy       <= w_busy_nxt;
            r_done       <= w_done_nxt;
        end
    end

    assign bus.freq_word  = r_freq_word;
    assign bus.amp_en     = r_amp_en;
    assign bus.phase_inv  = r_phase_inv;
    assign bus.acc_clr    = r_acc_clr;
    assign bus.sym_strobe = r_sym_strobe;
    assign bus.bit_idx    = r_bit_idx;
    assign bus.busy       = r_busy;
    assign bus.done       = r_done;
endmodule

// File: tb/tb_mod_sequencer.sv
// Scoreboard bench for mod_sequencer: stimulus queues expected symbols, a negedge monitor checks them.
module tb_mod_sequencer;
    localparam int          SYM = 4;
    localparam logic [15:0] F0  = 16'd100;
    localparam logic [15:0] F1  = 16'd200;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    mod_sequencer_if bus_if();

    mod_sequencer #(.SYM_CYCLES(SYM), .F0_WORD(F0), .F1_WORD(F1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] freq;
        logic        amp;
        logic        ph;
        logic [3:0]  idx;
        int          cyc;
    } sym_t;

    sym_t sym_q[$];
    int   done_q[$];
    int   clr_pending = 0;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    sym_t cur;
    bit   in_msg = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Reference: one symbol per message bit, MSB first, each SYM cycles long
    task automatic push_msg(input logic [9:0] sw, input logic [1:0] scheme, input int p);
        sym_t e;
        logic b;
        for (int i = 0; i < 10; i++) begin
            b     = sw[9-i];
            e.idx = 4'(i);
            e.cyc = p + 2 + SYM * i;
            case (scheme)
                2'b01:   begin e.freq = b ? F1 : F0; e.amp = 1'b1; e.ph = 1'b0; end
                2'b10:   begin e.freq = F0;          e.amp = 1'b1; e.ph = b;    end
                default: begin e.freq = F0;          e.amp = b;    e.ph = 1'b0; end
            endcase
            sym_q.push_back(e);
        end
        done_q.push_back(p + 2 + SYM * 10);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus_if.acc_clr) begin
                chk("acc_clr expected", clr_pending > 0, 1);
                if (clr_pending > 0) clr_pending--;
            end
            if (bus_if.sym_strobe) begin
                chk("sym_strobe expected", sym_q.size() > 0, 1);
                if (sym_q.size() > 0) begin
                    cur = sym_q.pop_front();
                    chk("strobe cycle", cyc, cur.cyc);
                    chk("strobe freq_word", bus_if.freq_word, cur.freq);
                    chk("strobe amp_en", bus_if.amp_en, cur.amp);
                    chk("strobe phase_inv", bus_if.phase_inv, cur.ph);
                    chk("strobe bit_idx", bus_if.bit_idx, cur.idx);
                    chk("strobe busy", bus_if.busy, 1);
                    in_msg = 1'b1;
                end
            end else if (bus_if.busy) begin
                if (in_msg) begin
                    chk("hold freq_word", bus_if.freq_word, cur.freq);
                    chk("hold amp_en", bus_if.amp_en, cur.amp);
                    chk("hold phase_inv", bus_if.phase_inv, cur.ph);
                    chk("hold bit_idx", bus_if.bit_idx, cur.idx);
                end else begin
                    chk("load freq_word", bus_if.freq_word, F0);
                    chk("load amp_en", bus_if.amp_en, 0);
                    chk("load phase_inv", bus_if.phase_inv, 0);
                end
            end else begin
                in_msg = 1'b0;
                chk("idle freq_word", bus_if.freq_word, F0);
                chk("idle amp_en", bus_if.amp_en, 0);
                chk("idle phase_inv", bus_if.phase_inv, 0);
            end
            if (bus_if.done) begin
                chk("done expected", done_q.size() > 0, 1);
                if (done_q.size() > 0) chk("done cycle", cyc, done_q.pop_front());
                chk("busy low at done", bus_if.busy, 0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while ((sym_q.size() != 0 || done_q.size() != 0 || bus_if.busy) && n < budget) begin
            tick();
            n++;
        end
        chk("message completes within budget", n < budget, 1);
    endtask

    task automatic send(input logic [9:0] sw, input logic [1:0] sch);
        bus_if.start = 1'b0;
        tick();
        bus_if.SW   = sw;
        bus_if.mode = sch[1];
        bus_if.sel  = sch[0];
        bus_if.start = 1'b1;
        push_msg(sw, sch, cyc);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, " freq_word"}, bus_if.freq_word, F0);
        chk({tag, " amp_en"}, bus_if.amp_en, 0);
        chk({tag, " phase_inv"}, bus_if.phase_inv, 0);
        chk({tag, " acc_clr"}, bus_if.acc_clr, 0);
        chk({tag, " sym_strobe"}, bus_if.sym_strobe, 0);
        chk({tag, " bit_idx"}, bus_if.bit_idx, 0);
        chk({tag, " busy"}, bus_if.busy, 0);
        chk({tag, " done"}, bus_if.done, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [9:0] sw;
        logic [1:0] sch;
        int n;

        bus_if.init  = 1'b0;
        bus_if.start = 1'b0;
        bus_if.SW    = 10'd0;
        bus_if.mode  = 1'b0;
        bus_if.sel   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_vals("reset");
        rst_n = 1'b1;
        tick();

        // init pulse from idle
        bus_if.init = 1'b1;
        clr_pending++;
        tick();
        chk("init acc_clr", bus_if.acc_clr, 1);
        chk("init busy", bus_if.busy, 0);
        bus_if.init = 1'b0;
        tick();
        chk("after init acc_clr", bus_if.acc_clr, 0);
        repeat (3) tick();

        // FSK, start held: one transmission only
        send(10'b1000110101, 2'b01);
        wait_idle(80);
        repeat (20) tick();

        // ASK with SW changed after LOAD
        send(10'b1000110101, 2'b00);
        tick();
        tick();
        bus_if.SW = 10'b1001101101;
        wait_idle(80);

        // PSK all ones
        send(10'h3FF, 2'b10);
        wait_idle(80);

        // abort at bit_idx 5
        sw  = 10'($urandom);
        sch = 2'($urandom_range(0, 3));
        send(sw, sch);
        n = 0;
        while (!(bus_if.sym_strobe && bus_if.bit_idx == 4'd5) && n < 100) begin
            tick();
            n++;
        end
        chk("reached bit_idx 5", n < 100, 1);
        tick();
        bus_if.init = 1'b1;
        sym_q.delete();
        done_q.delete();
        clr_pending++;
        tick();
        chk("abort acc_clr", bus_if.acc_clr, 1);
        chk("abort busy", bus_if.busy, 0);
        chk("abort done", bus_if.done, 0);
        bus_if.init = 1'b0;
        repeat (10) tick();
        send(sw, sch);
        wait_idle(80);

        // async reset mid-SEND, start held through release
        sw  = 10'($urandom);
        sch = 2'($urandom_range(0, 3));
        send(sw, sch);
        repeat (15) tick();
        rst_n = 1'b0;
        sym_q.delete();
        done_q.delete();
        #1;
        chk_reset_vals("async reset");
        repeat (2) tick();
        rst_n = 1'b1;
        push_msg(sw, sch, cyc);
        wait_idle(80);
        repeat (20) tick();

        // randomized messages with input disturbance mid-flight
        for (int t = 0; t < 6; t++) begin
            sw  = 10'($urandom);
            sch = 2'($urandom_range(0, 3));
            send(sw, sch);
            repeat ($urandom_range(2, 30)) tick();
            bus_if.SW   = 10'($urandom);
            bus_if.mode = 1'($urandom);
            bus_if.sel  = 1'($urandom);
            wait_idle(80);
        end
        repeat (10) tick();

        chk("scoreboard drained", sym_q.size() + done_q.size() + clr_pending, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
